// File: rtl/fc_seq_ctrl.sv
// Sequencer for the 4-lane fully-connected MAC datapath: walks fin/weight buffers,
// steers the datapath indices and collects per-channel results into the output buffer.
module fc_seq_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [11:0]       i_fin_div4_len,
    input  logic [11:0]       i_fout_len,
    input  logic [ADDR_W-1:0] i_wgt_base,
    input  logic              i_mac_req,
    input  logic              i_fc_fout_vld,
    input  logic [11:0]       i_real_fout_idx,
    output logic              o_fc_calc_ing,
    output logic [11:0]       o_proc_fin_idx,
    output logic [11:0]       o_proc_fout_idx,
    output logic [11:0]       o_fin_rd_addr,
    output logic [ADDR_W-1:0] o_wgt_rd_addr,
    output logic [11:0]       o_bias_rd_addr,
    output logic              o_fout_wr_en,
    output logic [11:0]       o_fout_wr_addr,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [11:0]       r_fin_len;
    logic [11:0]       r_fout_len;
    logic [11:0]       r_proc_fin_idx;
    logic [11:0]       r_proc_fout_idx;
    logic [ADDR_W-1:0] r_wgt_rd_addr;
    logic [11:0]       r_out_cnt;
    logic              r_fc_calc_ing;
    logic              r_busy;
    logic              r_done;

    logic              w_beat;
    logic              w_fin_last;
    logic              w_fout_last;
    logic              w_last_beat;
    logic              w_vld_acc;
    logic              w_out_complete;
    logic              w_start_ok;
    logic              w_zero_len;

    // r_fc_calc_ing is only ever set while in RUN, so a beat implies RUN
    assign w_beat         = r_fc_calc_ing & i_mac_req;
    assign w_fin_last     = (r_proc_fin_idx == (r_fin_len - 12'd1));
    assign w_fout_last    = (r_proc_fout_idx == (r_fout_len - 12'd1));
    assign w_last_beat    = w_beat & w_fin_last & w_fout_last;
    assign w_vld_acc      = i_fc_fout_vld & ((r_state == RUN) | (r_state == DRAIN));
    assign w_out_complete = w_vld_acc & ((r_out_cnt + 12'd1) == r_fout_len);
    assign w_start_ok     = i_start & ~i_abort & (r_state == IDLE);
    assign w_zero_len     = (i_fin_div4_len == 12'd0) | (i_fout_len == 12'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = w_zero_len ? DONE : RUN;
                end
            end
            RUN: begin
                // Result collection can finish ahead of the final beat bookkeeping
                if (w_out_complete) begin
                    w_state_nxt = DONE;
                end else if (w_last_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_complete) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (i_abort) begin
            w_state_nxt = IDLE;
        end
    end

    // Status flags are registered from the next state so they align with r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_calc_ing <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_fc_calc_ing <= (w_state_nxt == RUN);
            r_busy        <= (w_state_nxt == RUN) | (w_state_nxt == DRAIN);
            r_done        <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fin_len       <= '0;
            r_fout_len      <= '0;
            r_proc_fin_idx  <= '0;
            r_proc_fout_idx <= '0;
            r_wgt_rd_addr   <= '0;
            r_out_cnt       <= '0;
        end else if (i_abort) begin
            r_proc_fin_idx  <= '0;
            r_proc_fout_idx <= '0;
            r_wgt_rd_addr   <= '0;
            r_out_cnt       <= '0;
        end else if (w_start_ok) begin
            r_fin_len       <= i_fin_div4_len;
            r_fout_len      <= i_fout_len;
            r_proc_fin_idx  <= '0;
            r_proc_fout_idx <= '0;
            r_wgt_rd_addr   <= i_wgt_base;
            r_out_cnt       <= '0;
        end else begin
            if (w_beat) begin
                r_wgt_rd_addr <= r_wgt_rd_addr + ADDR_W'(1);
                if (w_fin_last) begin
                    r_proc_fin_idx  <= '0;
                    r_proc_fout_idx <= w_fout_last ? 12'd0 : (r_proc_fout_idx + 12'd1);
                end else begin
                    r_proc_fin_idx <= r_proc_fin_idx + 12'd1;
                end
            end
            if (w_vld_acc) begin
                r_out_cnt <= r_out_cnt + 12'd1;
            end
        end
    end

    assign o_fc_calc_ing   = r_fc_calc_ing;
    assign o_proc_fin_idx  = r_proc_fin_idx;
    assign o_proc_fout_idx = r_proc_fout_idx;
    assign o_fin_rd_addr   = r_proc_fin_idx;
    assign o_wgt_rd_addr   = r_wgt_rd_addr;
    assign o_bias_rd_addr  = i_real_fout_idx;
    assign o_fout_wr_en    = w_vld_acc;
    assign o_fout_wr_addr  = r_out_cnt;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: expected beats and write addresses are queued when a job
// is launched and popped as the sequencer issues them.
module tb_fc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] fin_len;
    logic [11:0] fout_len;
    logic [15:0] wgt_base;
    logic        mac_req;
    logic        vld;
    logic [11:0] real_idx;

    logic        fc_calc_ing;
    logic [11:0] proc_fin_idx;
    logic [11:0] proc_fout_idx;
    logic [11:0] fin_rd_addr;
    logic [15:0] wgt_rd_addr;
    logic [11:0] bias_rd_addr;
    logic        fout_wr_en;
    logic [11:0] fout_wr_addr;
    logic        busy;
    logic        done;

    int total  = 0;
    int passed = 0;

    logic [39:0] beat_q[$];
    logic [11:0] wr_q[$];

    always #5 clk = ~clk;

    fc_seq_ctrl #(.ADDR_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_abort         (abort),
        .i_fin_div4_len  (fin_len),
        .i_fout_len      (fout_len),
        .i_wgt_base      (wgt_base),
        .i_mac_req       (mac_req),
        .i_fc_fout_vld   (vld),
        .i_real_fout_idx (real_idx),
        .o_fc_calc_ing   (fc_calc_ing),
        .o_proc_fin_idx  (proc_fin_idx),
        .o_proc_fout_idx (proc_fout_idx),
        .o_fin_rd_addr   (fin_rd_addr),
        .o_wgt_rd_addr   (wgt_rd_addr),
        .o_bias_rd_addr  (bias_rd_addr),
        .o_fout_wr_en    (fout_wr_en),
        .o_fout_wr_addr  (fout_wr_addr),
        .o_busy          (busy),
        .o_done          (done)
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; fin_len = 0; fout_len = 0;
        wgt_base = 0; mac_req = 0; vld = 0; real_idx = 0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({fc_calc_ing, proc_fin_idx, proc_fout_idx, wgt_rd_addr, busy, done} !== 42'd0)
            $display("FAIL reset_regs: got %0h required 0",
                     {fc_calc_ing, proc_fin_idx, proc_fout_idx, wgt_rd_addr, busy, done});
        else passed++;
        total++;
        if ({fout_wr_addr, fout_wr_en} !== 13'd0)
            $display("FAIL reset_wr: got %0h required 0", {fout_wr_addr, fout_wr_en});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_job(input int fl, input int ol, input int base, input int bp, input int stray);
        int n = fl * ol;
        int beats = 0;
        int sent = 0;
        int dones = 0;
        int cyc = 0;
        bit seen_drain = 0;
        bit finished = 0;
        logic [39:0] e;
        logic [11:0] ea;
        for (int f = 0; f < ol; f++) begin
            for (int i = 0; i < fl; i++)
                beat_q.push_back({12'(i), 12'(f), 16'(base + f * fl + i)});
            wr_q.push_back(12'(f));
        end
        @(negedge clk);
        start = 1; fin_len = 12'(fl); fout_len = 12'(ol); wgt_base = 16'(base);
        mac_req = 0; vld = 0; abort = 0;
        @(negedge clk);
        start = 0;
        #1;
        total++;
        if ({fc_calc_ing, busy} !== 2'b11)
            $display("FAIL launch: calc/busy got %b required 11", {fc_calc_ing, busy});
        else passed++;
        while (!finished && cyc < 500) begin
            mac_req = (bp != 0) ? (cyc % 3 == 0) : 1'b1;
            if (stray != 0 && cyc == 2) begin
                start = 1; fin_len = 12'd7; fout_len = 12'd9; wgt_base = 16'h5555;
            end else begin
                start = 0;
            end
            vld = !fc_calc_ing && sent < ol && (cyc % 2 == 0);
            real_idx = 12'(sent);
            #1;
            if (fc_calc_ing && mac_req) begin
                beats++;
                total++;
                if (beat_q.size() == 0) begin
                    $display("FAIL extra_beat: got fin=%0d fout=%0d required no beat",
                             proc_fin_idx, proc_fout_idx);
                end else begin
                    e = beat_q.pop_front();
                    if ({proc_fin_idx, proc_fout_idx, wgt_rd_addr} !== e || fin_rd_addr !== proc_fin_idx)
                        $display("FAIL beat%0d: got %h/%0h required %h", beats,
                                 {proc_fin_idx, proc_fout_idx, wgt_rd_addr}, fin_rd_addr, e);
                    else passed++;
                end
            end
            if (!fc_calc_ing && busy && !seen_drain) begin
                seen_drain = 1;
                total++;
                if (wgt_rd_addr !== 16'(base + n))
                    $display("FAIL drain_wgt: got %h required %h", wgt_rd_addr, 16'(base + n));
                else passed++;
            end
            if (vld) begin
                total++;
                if (wr_q.size() == 0) begin
                    $display("FAIL extra_write: got addr %0d required none", fout_wr_addr);
                end else begin
                    ea = wr_q.pop_front();
                    if (fout_wr_en !== 1'b1 || fout_wr_addr !== ea || bias_rd_addr !== real_idx)
                        $display("FAIL write%0d: got en=%b addr=%0d bias=%0d required en=1 addr=%0d bias=%0d",
                                 sent, fout_wr_en, fout_wr_addr, bias_rd_addr, ea, real_idx);
                    else passed++;
                end
                sent++;
            end
            if (done) begin
                dones++;
                finished = 1;
                total++;
                if (busy !== 1'b0 || fc_calc_ing !== 1'b0)
                    $display("FAIL done_busy: got busy=%b calc=%b required 0/0", busy, fc_calc_ing);
                else passed++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0; vld = 0; mac_req = 0;
        #1;
        total++;
        if (!finished) $display("FAIL done_timeout: got no done required done within 500 cycles");
        else passed++;
        total++;
        if (beats !== n || beat_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL beat_count: got %0d beats (%0d/%0d left) required %0d",
                     beats, beat_q.size(), wr_q.size(), n);
        else passed++;
        total++;
        if ({done, busy, fc_calc_ing} !== 3'b000)
            $display("FAIL done_pulse: got done/busy/calc=%b required 000", {done, busy, fc_calc_ing});
        else passed++;
        beat_q.delete();
        wr_q.delete();
    endtask

    task automatic test_zero_len(input int fl, input int ol);
        @(negedge clk);
        start = 1; fin_len = 12'(fl); fout_len = 12'(ol); wgt_base = 16'h0300;
        mac_req = 1; vld = 0;
        @(negedge clk);
        start = 0; vld = 1;
        #1;
        total++;
        if ({done, busy, fc_calc_ing, fout_wr_en} !== 4'b1000)
            $display("FAIL zero_len_%0d_%0d: got done/busy/calc/wr=%b required 1000",
                     fl, ol, {done, busy, fc_calc_ing, fout_wr_en});
        else passed++;
        @(negedge clk);
        vld = 0; mac_req = 0;
        #1;
        total++;
        if ({done, busy, fc_calc_ing} !== 3'b000)
            $display("FAIL zero_len_after: got %b required 000", {done, busy, fc_calc_ing});
        else passed++;
    endtask

    task automatic test_abort();
        int beats = 0;
        bit aborted = 0;
        logic [39:0] e;
        @(negedge clk);
        start = 1; fin_len = 12'd3; fout_len = 12'd2; wgt_base = 16'h0040; mac_req = 0;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 20 && !aborted; c++) begin
            mac_req = 1;
            abort = (beats == 2);
            #1;
            if (fc_calc_ing && mac_req) begin
                e = {12'(beats % 3), 12'(beats / 3), 16'(16'h0040 + beats)};
                total++;
                if ({proc_fin_idx, proc_fout_idx, wgt_rd_addr} !== e)
                    $display("FAIL abort_beat%0d: got %h required %h", beats,
                             {proc_fin_idx, proc_fout_idx, wgt_rd_addr}, e);
                else passed++;
                beats++;
            end
            if (abort) aborted = 1;
            @(negedge clk);
        end
        abort = 0;
        #1;
        total++;
        if ({fc_calc_ing, proc_fin_idx, proc_fout_idx, wgt_rd_addr, busy, done, fout_wr_addr} !== 54'd0)
            $display("FAIL abort_idle: got %h required 0",
                     {fc_calc_ing, proc_fin_idx, proc_fout_idx, wgt_rd_addr, busy, done, fout_wr_addr});
        else passed++;
        begin
            bit saw_done = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                #1;
                if (done || busy) saw_done = 1;
            end
            total++;
            if (saw_done) $display("FAIL abort_no_done: got done/busy activity required none");
            else passed++;
        end
        mac_req = 0;
        run_job(3, 2, 16'h0080, 0, 0);
    endtask

    task automatic test_ignored();
        @(negedge clk);
        vld = 1; real_idx = 12'd5;
        #1;
        total++;
        if (fout_wr_en !== 1'b0)
            $display("FAIL idle_vld: got wr_en=%b required 0", fout_wr_en);
        else passed++;
        @(negedge clk);
        vld = 0;
        #1;
        total++;
        if ({busy, done} !== 2'b00)
            $display("FAIL idle_vld_state: got busy/done=%b required 00", {busy, done});
        else passed++;
        run_job(2, 2, 16'hFFFE, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_job(1, 1, 16'h1000, 0, 0);
        run_job(4, 3, 16'h2000, 1, 0);
    endtask

    initial begin
        test_reset();
        run_job(3, 2, 16'h0100, 0, 0);
        run_job(3, 2, 16'h0200, 1, 0);
        test_zero_len(3, 0);
        test_zero_len(0, 2);
        test_abort();
        test_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fc_seq_ctrl.md
# fc_seq_ctrl

Sequencer for the single-precision, 4-lane fully-connected MAC datapath. It does the following for one fully-connected layer:
- walks the input-feature and weight buffers,
- drives the datapath's `fc_calc_ing`, `proc_fin_idx` and `proc_fout_idx`,
- collects the datapath's `fc_fout_vld` results into the output buffer,
- signals `done` after all `fout_len` outputs are written.

It sits between the layer-level scheduler, which issues `start` and the lengths, and the fully-connected datapath.

## Interface
- `ADDR_W`, 16: weight-buffer address width, in 128-bit words.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle launch pulse; honoured only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `fin_div4_len`  in  12  input length / 4; latched on accepted `start`.
- `fout_len`  in  12  number of output channels; latched on accepted `start`.
- `wgt_base`  in  ADDR_W  weight-buffer base word address; latched on accepted `start`.
- `mac_req`  in  1  datapath ready to accept a 4-lane beat.
- `fc_fout_vld`  in  1  datapath output valid, 1 cycle per output channel.
- `real_fout_idx`  in  12  datapath's current output channel.
- `fc_calc_ing`  out  1  registered; high only in RUN.
- `proc_fin_idx`  out  12  registered; fin group index of the current beat.
- `proc_fout_idx`  out  12  registered; output channel of the current beat.
- `fin_rd_addr`  out  12  equals `proc_fin_idx`.
- `wgt_rd_addr`  out  ADDR_W  registered running weight word address.
- `bias_rd_addr`  out  12  equals `real_fout_idx`.
- `fout_wr_en`  out  1  equals `fc_fout_vld` while in RUN or DRAIN, else 0.
- `fout_wr_addr`  out  12  equals the output counter `out_cnt`.
- `busy`  out  1  registered; high in RUN and DRAIN.
- `done`  out  1  registered one-cycle pulse.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - On `start` with both lengths ≠ 0: latch the inputs, clear the counters, load `wgt_rd_addr` with `wgt_base`, and go to RUN.
  - On `start` with either length = 0: go to DONE. No beats are issued and nothing is written.
- **Beat definition:** a beat is `fc_calc_ing && mac_req`. Without a beat, all indices and addresses hold.
- **RUN, on each beat:**
  - `wgt_rd_addr` increments by 1, wrapping modulo 2^`ADDR_W`.
  - If `proc_fin_idx` = `fin_div4_len`−1: `proc_fin_idx` goes to 0 and `proc_fout_idx` increments.
  - Otherwise `proc_fin_idx` increments.
- **RUN exit:** the beat at (`proc_fin_idx` = `fin_div4_len`−1, `proc_fout_idx` = `fout_len`−1) is the last one.
  - Next state is DRAIN, with `fc_calc_ing` = 0.
  - Indices wrap to 0 and `wgt_rd_addr` increments as usual.
- **Output counter:** `out_cnt` increments on every `fc_fout_vld` seen in RUN or DRAIN.
- **DRAIN exit:** go to DONE when `out_cnt` reaches `fout_len`, counting a `fc_fout_vld` in the current cycle (count+1 = `fout_len`). This applies even if the last valid arrives while still in RUN.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE.
- **abort:** has priority over every other transition.
  - Next state is IDLE; `fc_calc_ing`, `busy` and `done` go to 0.
  - Counters are cleared; no `done` pulse is produced.
  - `start` in the same cycle as `abort` is ignored.
- **Ignored events:**
  - `start` outside IDLE.
  - `fc_fout_vld` in IDLE or DONE: no write, no count.
- **Buffers:** the input-feature, weight and bias buffers are combinational-read. The addresses present during a beat select the operands consumed by that beat.

## Timing
- **Reset values:** all registered outputs are 0: `fc_calc_ing`, `proc_fin_idx`, `proc_fout_idx`, `wgt_rd_addr`, `busy`, `done`. State = IDLE; `out_cnt` = 0.
- **Launch:** `start` sampled high at edge T gives `fc_calc_ing` = `busy` = 1 from T+1. The first beat can occur in cycle T+1.
- **Index update:** indices update on the edge after a beat, so back-to-back beats advance them every cycle.
- **End of RUN:** the last beat in cycle N gives `fc_calc_ing` = 0 from N+1.
- **Completion:** the final `fc_fout_vld` in cycle M gives `done` = 1 and `busy` = 0 in cycle M+1, and IDLE in M+2. A new `start` is accepted in M+2.
- **Zero-length run:** `start` at T gives `done` at T+1; `busy` stays 0.
- **Write side:** `fout_wr_en` and `fout_wr_addr` are combinational from `fc_fout_vld` and `out_cnt`, with zero latency.

## Test plan
- **Basic run:** `fin_div4_len`=3, `fout_len`=2, `wgt_base`=0x0100, `mac_req` held 1.
  - Exactly 6 beats, with (`fin`,`fout`) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - `wgt_rd_addr` runs 0x0100–0x0105, then reads 0x0106 in DRAIN.
  - `fc_calc_ing` falls after beat 6.
- **Drain and done:** same run with `fc_fout_vld` pulsed twice.
  - Writes go to `fout_wr_addr` 0 then 1.
  - `done` is high for exactly one cycle after the second valid; `busy` falls in that same cycle.
- **Back-pressure:** `mac_req` toggles 1,0,0,1,… → indices and `wgt_rd_addr` hold on the 0 cycles. The beat count is still exactly `fin_div4_len`×`fout_len`.
- **Zero length:** `fout_len`=0 with `start` → `done` the next cycle, no `fc_calc_ing`, no writes. Repeat with `fin_div4_len`=0.
- **Abort mid-RUN:** `abort` on beat 3 → IDLE next cycle with all outputs 0 and no `done`. A following `start` restarts at (0,0) with `wgt_base`.
- **Ignored events:** `start` while `busy`, and `fc_fout_vld` while in IDLE → no state, counter or write effects.
